// File: rtl/hex_uart_pkg.sv
// Shared types and ASCII helpers for the hex UART transmitter.
package hex_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] A_UC = 8'h41;

    localparam int NUM_CHARS = 6;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ZERO + {4'h0, nib};
        end
        return A_UC + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity
// (HEX_UART_TX_PARITY_EN), stop bit. A load on the last stop cycle chains bytes gap-free.
//
// state  | meaning
// IDLE   | line high, waiting for load
// START  | start bit (0)
// DATA   | data bits 0..7, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (1); last cycle reports byte_done and accepts the next load
module uart_tx_byte
    import hex_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          baud_last;
`ifdef HEX_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign baud_last = (baud_q == BAUD_LAST);
    assign byte_done = (state_q == STOP) && baud_last;
    assign ready     = (state_q == IDLE) || byte_done;
    assign tx        = tx_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
`ifdef HEX_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            START: if (baud_last) state_d = DATA;
            DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
`ifdef HEX_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end
            end
`ifdef HEX_UART_TX_PARITY_EN
            PARITY: if (baud_last) state_d = STOP;
`endif
            STOP: if (baud_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load && ready) begin
            state_d = START;
            bit_d   = 3'd0;
            sh_d    = byte_in;
`ifdef HEX_UART_TX_PARITY_EN
            par_d   = ^byte_in;
`endif
        end

        baud_d = ((state_q == IDLE) || baud_last) ? '0 : baud_q + CW'(1);

        // tx is registered from the next state so it changes on the same edge as the FSM
        case (state_d)
            START: tx_d = 1'b0;
            DATA:  tx_d = sh_d[0];
`ifdef HEX_UART_TX_PARITY_EN
            PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk100_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef HEX_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef HEX_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: rtl/hex_uart_tx.sv
// Sends a latched 16-bit value as four uppercase hex digits plus CR LF over UART.
// Define HEX_UART_TX_PARITY_EN for an even parity bit on every character.
module hex_uart_tx
    import hex_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk100_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] data_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    logic        busy_q, done_q;
    logic [15:0] data_q;
    logic [2:0]  char_idx;
    logic        accept, last_char, load, tx_ready, byte_done;
    logic [7:0]  byte_in;

    assign accept    = start_i && !busy_q && tx_ready;
    assign last_char = (char_idx == 3'(NUM_CHARS - 1));
    assign load      = accept || (busy_q && byte_done && !last_char);
    assign busy_o    = busy_q;
    assign done_o    = done_q;

    // On acceptance the first digit comes straight from data_i; afterwards
    // the byte loaded is the one following char_idx.
    always_comb begin
        byte_in = nib2ascii(data_i[15:12]);
        if (!accept) begin
            case (char_idx)
                3'd0:    byte_in = nib2ascii(data_q[11:8]);
                3'd1:    byte_in = nib2ascii(data_q[7:4]);
                3'd2:    byte_in = nib2ascii(data_q[3:0]);
                3'd3:    byte_in = CR;
                default: byte_in = LF;
            endcase
        end
    end

    always_ff @(posedge clk100_i) begin
        if (!rst_i) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            char_idx <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q   <= 1'b1;
                data_q   <= data_i;
                char_idx <= '0;
            end else if (busy_q && byte_done) begin
                if (last_char) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    char_idx <= char_idx + 3'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .load     (load),
        .byte_in  (byte_in),
        .ready    (tx_ready),
        .byte_done(byte_done),
        .tx       (tx_o)
    );

endmodule

// File: tb/tb_hex_uart_tx.sv
// Directed bench for hex_uart_tx at 16 clocks per bit with an independent UART receiver model.
module tb_hex_uart_tx;

    localparam int CPB = 16;
`ifdef HEX_UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME = 6 * BITS * CPB;

    logic        clk100_i = 1'b0;
    logic        rst_i    = 1'b0;
    logic        start_i  = 1'b0;
    logic [15:0] data_i   = 16'h0000;
    logic        tx_o, busy_o, done_o;

    int total = 0;
    int bad   = 0;

    hex_uart_tx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk100_i(clk100_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .data_i  (data_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk100_i = ~clk100_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Receiver model: detect falling edge, sample each bit mid-way
    logic       rx_abort = 1'b0;
    int         rx_busy  = 0;
    int         rx_cnt   = 0;
    int         rx_n     = 0;
    int         rx_err   = 0;
    logic [7:0] rx_sh    = 8'h00;
    logic [7:0] rx_bytes [256];
`ifdef HEX_UART_TX_PARITY_EN
    logic       rx_p = 1'b0;
    logic       rx_pars [256];
`endif

    always @(negedge clk100_i) begin
        if (rx_abort) begin
            rx_busy = 0;
        end else if (rx_busy == 0) begin
            if (tx_o === 1'b0) begin
                rx_busy = 1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt = rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) begin
                int b;
                b = rx_cnt / CPB;
                if (b == 0 && tx_o !== 1'b0) rx_err = rx_err + 1;
                if (b >= 1 && b <= 8) rx_sh[b-1] = tx_o;
`ifdef HEX_UART_TX_PARITY_EN
                if (b == 9) rx_p = tx_o;
`endif
                if (b == BITS - 1) begin
                    if (tx_o !== 1'b1) rx_err = rx_err + 1;
                    rx_bytes[rx_n % 256] = rx_sh;
`ifdef HEX_UART_TX_PARITY_EN
                    rx_pars[rx_n % 256] = rx_p;
`endif
                    rx_n    = rx_n + 1;
                    rx_busy = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge where done_o is seen (chain=1)
    // or one cycle later after checking done_o fell (chain=0).
    task automatic send_frame(input logic [15:0] d, input logic [47:0] exp_c,
                              input logic [5:0] exp_p, input string tag,
                              input bit noise, input bit chain);
        int base, cnt, done_seen;
        base    = rx_n;
        data_i  = d;
        start_i = 1'b1;
        @(negedge clk100_i);
        start_i = 1'b0;
        chk($sformatf("%s latency tx", tag), int'(tx_o), 0);
        chk($sformatf("%s latency busy", tag), int'(busy_o), 1);
        cnt       = 0;
        done_seen = 0;
        while (busy_o === 1'b1 && cnt < 3 * FRAME) begin
            if (done_o === 1'b1) done_seen = done_seen + 1;
            if (noise && (cnt == 5 || cnt == 300)) begin
                start_i = 1'b1;
                data_i  = 16'hFFFF;
            end else begin
                start_i = 1'b0;
            end
            cnt = cnt + 1;
            @(negedge clk100_i);
        end
        start_i = 1'b0;
        chk($sformatf("%s busy cycles", tag), cnt, FRAME);
        chk($sformatf("%s done while busy", tag), done_seen, 0);
        chk($sformatf("%s done at end", tag), int'(done_o), 1);
        chk($sformatf("%s tx idle at end", tag), int'(tx_o), 1);
        chk($sformatf("%s char count", tag), rx_n - base, 6);
        chk($sformatf("%s framing errors", tag), rx_err, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s char %0d", tag, i), int'(rx_bytes[(base + i) % 256]),
                int'(exp_c[47 - 8 * i -: 8]));
`ifdef HEX_UART_TX_PARITY_EN
            chk($sformatf("%s parity %0d", tag, i), int'(rx_pars[(base + i) % 256]),
                int'(exp_p[5 - i]));
`endif
        end
        if (!chain) begin
            @(negedge clk100_i);
            chk($sformatf("%s done pulse width", tag), int'(done_o), 0);
        end
    endtask

    typedef struct packed {
        logic [15:0] data;
        logic [47:0] chars;
        logic [5:0]  par;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int errs;
        vecs[0] = '{data: 16'h1A2F, chars: 48'h31_41_32_46_0D_0A, par: 6'b101110};
        vecs[1] = '{data: 16'h0007, chars: 48'h30_30_30_37_0D_0A, par: 6'b000110};
        vecs[2] = '{data: 16'hBEEF, chars: 48'h42_45_45_46_0D_0A, par: 6'b011110};
        vecs[3] = '{data: 16'h9C50, chars: 48'h39_43_35_30_0D_0A, par: 6'b010010};

        // Reset with start_i held: reset must win
        start_i = 1'b1;
        data_i  = 16'hABCD;
        repeat (3) @(negedge clk100_i);
        chk("reset tx", int'(tx_o), 1);
        chk("reset busy", int'(busy_o), 0);
        chk("reset done", int'(done_o), 0);
        start_i = 1'b0;
        rst_i   = 1'b1;

        errs = 0;
        repeat (50) begin
            @(negedge clk100_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) errs = errs + 1;
        end
        chk("idle outputs", errs, 0);
        chk("idle no chars", rx_n, 0);

        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].data, vecs[v].chars, vecs[v].par,
                       $sformatf("vec%0d", v), 1'b0, 1'b0);
            repeat (3) @(negedge clk100_i);
        end

        // Ignored starts and data change mid-frame, then a start in the done cycle
        send_frame(16'h09F0, 48'h30_39_46_30_0D_0A, 6'b001010, "noise", 1'b1, 1'b1);
        send_frame(16'h0000, 48'h30_30_30_30_0D_0A, 6'b000010, "b2b", 1'b0, 1'b0);

        // Reset 400 cycles into a frame
        repeat (2) @(negedge clk100_i);
        data_i  = 16'h1234;
        start_i = 1'b1;
        @(negedge clk100_i);
        start_i = 1'b0;
        repeat (399) @(negedge clk100_i);
        rst_i    = 1'b0;
        rx_abort = 1'b1;
        @(negedge clk100_i);
        chk("midreset tx", int'(tx_o), 1);
        chk("midreset busy", int'(busy_o), 0);
        chk("midreset done", int'(done_o), 0);
        rst_i = 1'b1;
        errs  = 0;
        repeat (30) begin
            @(negedge clk100_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) errs = errs + 1;
        end
        chk("post reset quiet", errs, 0);
        rx_abort = 1'b0;
        send_frame(16'h5A3C, 48'h35_41_33_43_0D_0A, 6'b000110, "after_rst", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
